// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
//  Module   : cpu_ctrl_pkg
//  Purpose  : Opcode, ALU-class and branch-type encodings plus the control
//             word shared by the decode stage and its combinational decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  localparam int unsigned c_OPC_W       = 6;
  localparam int unsigned c_FUNCT_W     = 6;
  localparam int unsigned c_ALU_CLASS_W = 4;
  localparam int unsigned c_BT_W        = 2;

  // Opcodes
  localparam logic [c_OPC_W-1:0] c_OPC_R    = 6'd0;
  localparam logic [c_OPC_W-1:0] c_OPC_BGEZ = 6'd1;
  localparam logic [c_OPC_W-1:0] c_OPC_J    = 6'd2;
  localparam logic [c_OPC_W-1:0] c_OPC_BEQ  = 6'd4;
  localparam logic [c_OPC_W-1:0] c_OPC_BNE  = 6'd5;
  localparam logic [c_OPC_W-1:0] c_OPC_BNEZ = 6'd6;
  localparam logic [c_OPC_W-1:0] c_OPC_BGT  = 6'd7;
  localparam logic [c_OPC_W-1:0] c_OPC_ADDI = 6'd8;
  localparam logic [c_OPC_W-1:0] c_OPC_SLTI = 6'd10;
  localparam logic [c_OPC_W-1:0] c_OPC_ORI  = 6'd13;
  localparam logic [c_OPC_W-1:0] c_OPC_LUI  = 6'd15;
  localparam logic [c_OPC_W-1:0] c_OPC_LW   = 6'd35;
  localparam logic [c_OPC_W-1:0] c_OPC_SW   = 6'd43;

  // ALU operation classes; zero is reserved for bubbles and jumps
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_NONE = 4'd0;
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_R    = 4'd1;
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_ADDI = 4'd2;
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_SLTI = 4'd3;
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_BEQ  = 4'd4;
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_LUI  = 4'd5;
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_ORI  = 4'd6;
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_BNE  = 4'd7;
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_LW   = 4'd8;
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_SW   = 4'd9;
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_BGT  = 4'd10;
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_BNEZ = 4'd11;
  localparam logic [c_ALU_CLASS_W-1:0] c_ALU_BGEZ = 4'd12;

  // Branch types; BGEZ and BNEZ share an encoding and are split by ALU class
  localparam logic [c_BT_W-1:0] c_BT_BEQ  = 2'b00;
  localparam logic [c_BT_W-1:0] c_BT_BNE  = 2'b01;
  localparam logic [c_BT_W-1:0] c_BT_BGT  = 2'b10;
  localparam logic [c_BT_W-1:0] c_BT_BZ   = 2'b11;

  typedef struct packed {
    logic                     reg_write;
    logic                     alu_src;
    logic                     reg_dst;
    logic                     branch;
    logic                     jump;
    logic                     mem_read;
    logic                     mem_write;
    logic                     mem_to_reg;
    logic [c_ALU_CLASS_W-1:0] alu_op;
    logic [c_BT_W-1:0]        branch_type;
  } ctrl_word_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode_comb.sv
// ============================================================================
//  Module   : ctrl_decode_comb
//  Purpose  : Purely combinational opcode/funct to control-word decoder with
//             illegal-opcode and reads-rt flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decode_comb
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned EXT_BRANCH = 1
) (
  input  logic [c_OPC_W-1:0]   opcode_i,
  input  logic [c_FUNCT_W-1:0] funct_i,
  output ctrl_word_t           word_o,
  output logic                 illegal_o,
  output logic                 reads_rt_o
);

  logic w_ext;
  logic w_is_r, w_is_addi, w_is_slti, w_is_beq, w_is_bne, w_is_lui;
  logic w_is_ori, w_is_lw, w_is_sw, w_is_j, w_is_bgt, w_is_bgez, w_is_bnez;
  logic w_is_branch, w_legal;

  assign w_ext     = (EXT_BRANCH != 0);

  assign w_is_r    = (opcode_i == c_OPC_R);
  assign w_is_addi = (opcode_i == c_OPC_ADDI);
  assign w_is_slti = (opcode_i == c_OPC_SLTI);
  assign w_is_beq  = (opcode_i == c_OPC_BEQ);
  assign w_is_bne  = (opcode_i == c_OPC_BNE);
  assign w_is_lui  = (opcode_i == c_OPC_LUI);
  assign w_is_ori  = (opcode_i == c_OPC_ORI);
  assign w_is_lw   = (opcode_i == c_OPC_LW);
  assign w_is_sw   = (opcode_i == c_OPC_SW);
  assign w_is_j    = (opcode_i == c_OPC_J);
  // Extended branches only exist when enabled; otherwise they fall to illegal
  assign w_is_bgt  = w_ext & (opcode_i == c_OPC_BGT);
  assign w_is_bgez = w_ext & (opcode_i == c_OPC_BGEZ);
  assign w_is_bnez = w_ext & (opcode_i == c_OPC_BNEZ);

  assign w_is_branch = w_is_beq | w_is_bne | w_is_bgt | w_is_bgez | w_is_bnez;
  assign w_legal     = w_is_r | w_is_addi | w_is_slti | w_is_lui | w_is_ori |
                       w_is_lw | w_is_sw | w_is_j | w_is_branch;

  assign illegal_o  = ~w_legal;
  assign reads_rt_o = w_is_r | w_is_sw | w_is_beq | w_is_bne | w_is_bgt;

  always_comb begin
    word_o = '0;
    if (w_legal) begin
      word_o.reg_write  = w_is_r | w_is_addi | w_is_slti | w_is_lui | w_is_ori | w_is_lw;
      word_o.alu_src    = ~(w_is_r | w_is_branch);
      word_o.reg_dst    = w_is_r & (funct_i != '0);
      word_o.branch     = w_is_branch;
      word_o.jump       = w_is_j;
      word_o.mem_read   = w_is_lw;
      word_o.mem_write  = w_is_sw;
      word_o.mem_to_reg = ~w_is_lw;

      if (w_is_bne)                    word_o.branch_type = c_BT_BNE;
      else if (w_is_bgt)               word_o.branch_type = c_BT_BGT;
      else if (w_is_bgez | w_is_bnez)  word_o.branch_type = c_BT_BZ;
      else                             word_o.branch_type = c_BT_BEQ;

      if (w_is_r)         word_o.alu_op = c_ALU_R;
      else if (w_is_addi) word_o.alu_op = c_ALU_ADDI;
      else if (w_is_slti) word_o.alu_op = c_ALU_SLTI;
      else if (w_is_beq)  word_o.alu_op = c_ALU_BEQ;
      else if (w_is_lui)  word_o.alu_op = c_ALU_LUI;
      else if (w_is_ori)  word_o.alu_op = c_ALU_ORI;
      else if (w_is_bne)  word_o.alu_op = c_ALU_BNE;
      else if (w_is_lw)   word_o.alu_op = c_ALU_LW;
      else if (w_is_sw)   word_o.alu_op = c_ALU_SW;
      else if (w_is_bgt)  word_o.alu_op = c_ALU_BGT;
      else if (w_is_bnez) word_o.alu_op = c_ALU_BNEZ;
      else if (w_is_bgez) word_o.alu_op = c_ALU_BGEZ;
      else                word_o.alu_op = c_ALU_NONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ctrl_stage.sv
// ============================================================================
//  Module   : id_ctrl_stage
//  Purpose  : Registered ID/EX control stage: decode, load-use stall with
//             bubble insertion, flush handling and illegal-opcode pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ctrl_stage
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W   = 4,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned EXT_BRANCH = 1,
  parameter int unsigned HAZARD_EN  = 1
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic [31:0]         instr_i,
  input  logic                instr_valid_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                ex_valid_o,
  output logic                RegWrite_o,
  output logic                ALUSrc_o,
  output logic                RegDst_o,
  output logic                Branch_o,
  output logic                Jump_o,
  output logic                MemRead_o,
  output logic                MemWrite_o,
  output logic                MemtoReg_o,
  output logic [1:0]          BranchType_o,
  output logic [ALU_OP_W-1:0] ALU_op_o,
  output logic [REG_AW-1:0]   rs_o,
  output logic [REG_AW-1:0]   rt_o,
  output logic [REG_AW-1:0]   rd_o,
  output logic                illegal_o
);

  ctrl_word_t        w_word;
  logic              w_illegal;
  logic              w_reads_rt;
  logic              w_hazard;
  logic [REG_AW-1:0] w_rs, w_rt, w_rd;
  logic [4:0]        w_unused_shamt;

  logic              ex_valid_q, ex_valid_d;
  ctrl_word_t        word_q, word_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              illegal_q, illegal_d;

  ctrl_decode_comb #(
    .EXT_BRANCH (EXT_BRANCH)
  ) u_decode (
    .opcode_i   (instr_i[31:26]),
    .funct_i    (instr_i[5:0]),
    .word_o     (w_word),
    .illegal_o  (w_illegal),
    .reads_rt_o (w_reads_rt)
  );

  assign w_rs = REG_AW'(instr_i[25:21]);
  assign w_rt = REG_AW'(instr_i[20:16]);
  assign w_rd = REG_AW'(instr_i[15:11]);
  assign w_unused_shamt = instr_i[10:6];

  // A load in EX whose destination is needed now cannot forward in time
  generate
    if (HAZARD_EN != 0) begin : g_hazard
      assign w_hazard = ex_valid_q & word_q.mem_read & (rt_q != '0) & instr_valid_i &
                        ((rt_q == w_rs) | ((rt_q == w_rt) & w_reads_rt));
    end else begin : g_no_hazard
      assign w_hazard = 1'b0;
    end
  endgenerate

  assign stall_o = w_hazard & ~flush_i;

  always_comb begin
    ex_valid_d = 1'b0;
    word_d     = '0;
    rs_d       = '0;
    rt_d       = '0;
    rd_d       = '0;
    illegal_d  = 1'b0;
    if (!flush_i && !w_hazard && instr_valid_i) begin
      if (w_illegal) begin
        illegal_d = 1'b1;
      end else begin
        ex_valid_d = 1'b1;
        word_d     = w_word;
        rs_d       = w_rs;
        rt_d       = w_rt;
        rd_d       = w_rd;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      word_q     <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      illegal_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      word_q     <= word_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign RegWrite_o   = word_q.reg_write;
  assign ALUSrc_o     = word_q.alu_src;
  assign RegDst_o     = word_q.reg_dst;
  assign Branch_o     = word_q.branch;
  assign Jump_o       = word_q.jump;
  assign MemRead_o    = word_q.mem_read;
  assign MemWrite_o   = word_q.mem_write;
  assign MemtoReg_o   = word_q.mem_to_reg;
  assign BranchType_o = word_q.branch_type;
  assign ALU_op_o     = ALU_OP_W'(word_q.alu_op);
  assign rs_o         = rs_q;
  assign rt_o         = rt_q;
  assign rd_o         = rd_q;
  assign illegal_o    = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ctrl_stage.sv
// ============================================================================
//  Module   : tb_id_ctrl_stage
//  Purpose  : Self-checking bench for id_ctrl_stage with extended branches on
//             and off, checked every cycle against an opcode-table model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ctrl_stage;

  typedef struct packed {
    logic       v, rw, src, rdst, br, j, mr, mw, m2r;
    logic [1:0] bt;
    logic [3:0] alu;
    logic [4:0] rs, rt, rd;
    logic       ill;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        valid;
  logic        flush;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic       st_e, v_e, rw_e, src_e, rdst_e, br_e, j_e, mr_e, mw_e, m2r_e, ill_e;
  logic [1:0] bt_e;
  logic [3:0] alu_e;
  logic [4:0] rs_e, rt_e, rd_e;
  logic       st_b, v_b, rw_b, src_b, rdst_b, br_b, j_b, mr_b, mw_b, m2r_b, ill_b;
  logic [1:0] bt_b;
  logic [3:0] alu_b;
  logic [4:0] rs_b, rt_b, rd_b;

  slot_t act_e, act_b, m_e, m_b;
  assign act_e = {v_e, rw_e, src_e, rdst_e, br_e, j_e, mr_e, mw_e, m2r_e, bt_e, alu_e, rs_e, rt_e, rd_e, ill_e};
  assign act_b = {v_b, rw_b, src_b, rdst_b, br_b, j_b, mr_b, mw_b, m2r_b, bt_b, alu_b, rs_b, rt_b, rd_b, ill_b};

  always #5 clk = ~clk;

  id_ctrl_stage #(.ALU_OP_W(4), .REG_AW(5), .EXT_BRANCH(1), .HAZARD_EN(1)) u_dut_ext (
    .clk_i(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(valid), .flush_i(flush),
    .stall_o(st_e), .ex_valid_o(v_e), .RegWrite_o(rw_e), .ALUSrc_o(src_e), .RegDst_o(rdst_e),
    .Branch_o(br_e), .Jump_o(j_e), .MemRead_o(mr_e), .MemWrite_o(mw_e), .MemtoReg_o(m2r_e),
    .BranchType_o(bt_e), .ALU_op_o(alu_e), .rs_o(rs_e), .rt_o(rt_e), .rd_o(rd_e), .illegal_o(ill_e));

  id_ctrl_stage #(.ALU_OP_W(4), .REG_AW(5), .EXT_BRANCH(0), .HAZARD_EN(1)) u_dut_base (
    .clk_i(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(valid), .flush_i(flush),
    .stall_o(st_b), .ex_valid_o(v_b), .RegWrite_o(rw_b), .ALUSrc_o(src_b), .RegDst_o(rdst_b),
    .Branch_o(br_b), .Jump_o(j_b), .MemRead_o(mr_b), .MemWrite_o(mw_b), .MemtoReg_o(m2r_b),
    .BranchType_o(bt_b), .ALU_op_o(alu_b), .rs_o(rs_b), .rt_o(rt_b), .rd_o(rd_b), .illegal_o(ill_b));

  // Opcode table: {RegWrite ALUSrc RegDst Branch Jump MemRead MemWrite MemtoReg}, BranchType, ALU class
  function automatic slot_t decode(input logic [31:0] ins, input bit ext);
    slot_t       s;
    logic [13:0] ctl;
    bit          known;
    s     = '0;
    ctl   = '0;
    known = 1'b1;
    case (ins[31:26])
      6'd0:  ctl = {8'b10000001, 2'd0, 4'd1};
      6'd8:  ctl = {8'b11000001, 2'd0, 4'd2};
      6'd10: ctl = {8'b11000001, 2'd0, 4'd3};
      6'd4:  ctl = {8'b00010001, 2'd0, 4'd4};
      6'd15: ctl = {8'b11000001, 2'd0, 4'd5};
      6'd13: ctl = {8'b11000001, 2'd0, 4'd6};
      6'd5:  ctl = {8'b00010001, 2'd1, 4'd7};
      6'd35: ctl = {8'b11000100, 2'd0, 4'd8};
      6'd43: ctl = {8'b01000011, 2'd0, 4'd9};
      6'd2:  ctl = {8'b01001001, 2'd0, 4'd0};
      6'd7:  if (ext) ctl = {8'b00010001, 2'd2, 4'd10}; else known = 1'b0;
      6'd6:  if (ext) ctl = {8'b00010001, 2'd3, 4'd11}; else known = 1'b0;
      6'd1:  if (ext) ctl = {8'b00010001, 2'd3, 4'd12}; else known = 1'b0;
      default: known = 1'b0;
    endcase
    if (!known) begin
      s.ill = 1'b1;
    end else begin
      {s.rw, s.src, s.rdst, s.br, s.j, s.mr, s.mw, s.m2r, s.bt, s.alu} = ctl;
      if (ins[31:26] == 6'd0) s.rdst = (ins[5:0] != 6'd0);
      s.v  = 1'b1;
      s.rs = ins[25:21];
      s.rt = ins[20:16];
      s.rd = ins[15:11];
    end
    return s;
  endfunction

  function automatic bit load_use(input slot_t ex, input logic [31:0] ins, input logic v, input bit ext);
    logic [5:0] op;
    bit         rd_rt;
    op    = ins[31:26];
    rd_rt = (op == 6'd0) || (op == 6'd43) || (op == 6'd4) || (op == 6'd5) || (ext && op == 6'd7);
    return ex.v && ex.mr && (ex.rt != 5'd0) && v &&
           ((ex.rt == ins[25:21]) || (rd_rt && ex.rt == ins[20:16]));
  endfunction

  function automatic slot_t next_slot(input slot_t ex, input logic [31:0] ins, input logic v,
                                      input logic f, input bit ext);
    if (f || !v || load_use(ex, ins, v, ext)) return '0;
    return decode(ins, ext);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e <= '0;
      m_b <= '0;
    end else begin
      m_e <= next_slot(m_e, instr, valid, flush, 1'b1);
      m_b <= next_slot(m_b, instr, valid, flush, 1'b0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ext_outputs",  32'(act_e), 32'(m_e));
      chk("ext_stall",    32'(st_e),  32'(load_use(m_e, instr, valid, 1'b1) && !flush));
      chk("base_outputs", 32'(act_b), 32'(m_b));
      chk("base_stall",   32'(st_b),  32'(load_use(m_b, instr, valid, 1'b0) && !flush));
    end
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt);
    return {op, rs, rt, 16'h0010};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic f);
    @(posedge clk);
    #2;
    instr = ins;
    valid = v;
    flush = f;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd2;
      default: return 5'd9;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [16];
    logic [5:0] fn;
    ops = '{6'd0, 6'd8, 6'd10, 6'd4, 6'd5, 6'd15, 6'd13, 6'd35,
            6'd35, 6'd43, 6'd2, 6'd7, 6'd1, 6'd6, 6'd3, 6'd63};
    fn  = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
    return {ops[$urandom_range(0, 15)], pick_reg(), pick_reg(), pick_reg(), 5'($urandom), fn};
  endfunction

  initial begin
    instr = itype(6'd8, 5'd1, 5'd2);
    valid = 1'b1;
    flush = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // Reset holds everything low even with a valid ADDI presented
    repeat (2) @(negedge clk);
    chk("rst_ex_valid", 32'(v_e), 32'd0);
    chk("rst_alu_op",   32'(alu_e), 32'd0);
    chk("rst_regwrite", 32'(rw_e), 32'd0);
    chk("rst_stall",    32'(st_e), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("first_ex_valid", 32'(v_e), 32'd1);
    chk("first_alu_op",   32'(alu_e), 32'd2);
    chk("first_regwrite", 32'(rw_e), 32'd1);
    chk("first_alusrc",   32'(src_e), 32'd1);

    // Load-use: LW rt=9 then ADD rs=9
    drive(itype(6'd35, 5'd4, 5'd9), 1'b1, 1'b0);
    drive(rtype(5'd9, 5'd10, 5'd11, 6'd32), 1'b1, 1'b0);
    @(negedge clk);
    chk("lu_stall",   32'(st_e), 32'd1);
    chk("lu_ex_rt",   32'(rt_e), 32'd9);
    drive(rtype(5'd9, 5'd10, 5'd11, 6'd32), 1'b1, 1'b0);
    @(negedge clk);
    chk("lu_bubble",  32'(v_e), 32'd0);
    chk("lu_stall_1cyc", 32'(st_e), 32'd0);
    drive(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_add_valid",  32'(v_e), 32'd1);
    chk("lu_add_alu",    32'(alu_e), 32'd1);
    chk("lu_add_regdst", 32'(rdst_e), 32'd1);

    // No false stalls
    drive(itype(6'd35, 5'd4, 5'd0), 1'b1, 1'b0);
    drive(rtype(5'd0, 5'd5, 5'd6, 6'd32), 1'b1, 1'b0);
    @(negedge clk);
    chk("nofs_rt0", 32'(st_e), 32'd0);
    drive(itype(6'd35, 5'd4, 5'd9), 1'b1, 1'b0);
    drive(itype(6'd8, 5'd3, 5'd9), 1'b1, 1'b0);
    @(negedge clk);
    chk("nofs_addi_rt", 32'(st_e), 32'd0);
    drive(itype(6'd35, 5'd4, 5'd9), 1'b1, 1'b0);
    drive(itype(6'd35, 5'd5, 5'd9), 1'b1, 1'b0);
    @(negedge clk);
    chk("lw_lw_rt_only", 32'(st_e), 32'd0);
    drive(itype(6'd35, 5'd9, 5'd2), 1'b1, 1'b0);
    @(negedge clk);
    chk("lw_lw_rs_match", 32'(st_e), 32'd1);

    // Flush beats hazard
    drive(itype(6'd35, 5'd4, 5'd9), 1'b1, 1'b0);
    drive(rtype(5'd9, 5'd10, 5'd11, 6'd32), 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_stall", 32'(st_e), 32'd0);
    drive(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_bubble",  32'(v_e), 32'd0);
    chk("flush_illegal", 32'(ill_e), 32'd0);

    // BGT decoded when enabled, illegal otherwise
    drive(itype(6'd7, 5'd3, 5'd4), 1'b1, 1'b0);
    drive(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bgt_branch", 32'(br_e), 32'd1);
    chk("bgt_btype",  32'(bt_e), 32'd2);
    chk("bgt_alu",    32'(alu_e), 32'd10);
    chk("bgt_base_valid",   32'(v_b), 32'd0);
    chk("bgt_base_illegal", 32'(ill_b), 32'd1);
    drive(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bgt_base_ill_pulse", 32'(ill_b), 32'd0);

    // Asynchronous reset while stalled
    drive(itype(6'd35, 5'd4, 5'd9), 1'b1, 1'b0);
    drive(rtype(5'd9, 5'd10, 5'd11, 6'd32), 1'b1, 1'b0);
    @(negedge clk);
    chk("ar_stall_before", 32'(st_e), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_ex_valid", 32'(v_e), 32'd0);
    chk("ar_memread",  32'(mr_e), 32'd0);
    chk("ar_rt",       32'(rt_e), 32'd0);
    chk("ar_stall",    32'(st_e), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(rand_instr(), ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 10));
    end
    drive(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ctrl_stage.md
Name: id_ctrl_stage

Overview:
- Registered instruction-decode control stage for the pipelined CPU. Sits between the IF/ID register and the EX stage.
- Decodes opcode/funct into the full control word and registers it as the ID/EX control register with a valid bit.
- Detects load-use hazards, stalls IF/ID and inserts a bubble. Honours branch/jump flush.
- Successor to the combinational decoder: parametrised ALU-op width, optional extended branches (BGT/BGEZ/BNEZ) and illegal-opcode reporting.

Parameters:
ALU_OP_W, 4, width of ALU_op_o
REG_AW, 5, register address width
EXT_BRANCH, 1, 1 = decode BGT/BGEZ/BNEZ; 0 = those opcodes are illegal
HAZARD_EN, 1, 1 = load-use detection active; 0 = stall_o tied low

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
instr_i  in  32  instruction from IF/ID
instr_valid_i  in  1  instr_i holds a real instruction
flush_i  in  1  branch taken/jump: kill the instruction in ID
stall_o  out  1  combinational: hold PC and IF/ID this cycle
ex_valid_o  out  1  registered: EX-stage slot holds a real instruction
RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, Jump_o, MemRead_o, MemWrite_o, MemtoReg_o  out  1 each  registered control
BranchType_o  out  2  00 BEQ, 01 BNE, 10 BGT, 11 BGEZ/BNEZ (subtype via ALU_op_o)
ALU_op_o  out  ALU_OP_W  registered ALU operation class
rs_o, rt_o, rd_o  out  REG_AW each  registered register addresses
illegal_o  out  1  registered one-cycle pulse on an unknown opcode

Behaviour:
- Opcodes: R=0, ADDI=8, SLTI=10, BEQ=4, BNE=5, LUI=15, ORI=13, LW=35, SW=43, J=2. With EXT_BRANCH: BGT=7, BGEZ=1, BNEZ=6.
- ALU_op classes: R=1, ADDI=2, SLTI=3, BEQ=4, LUI=5, ORI=6, BNE=7, LW=8, SW=9, BGT=10, BNEZ=11, BGEZ=12.
- Decode:
  - ALUSrc=0 for R-type and all branches, else 1.
  - RegDst=1 only for R-type with funct!=0.
  - RegWrite=1 for R, ADDI, SLTI, LUI, ORI, LW.
  - Branch=1 for all branch opcodes. Jump=1 for J. MemRead=1 for LW. MemWrite=1 for SW.
  - MemtoReg=0 selects memory data (LW only), 1 selects ALU result.
- Latency: one cycle. A decision made in cycle n appears on the outputs after edge n+1.
- Bubble = ex_valid_o=0 with all control outputs 0 and ALU_op_o=0. Address outputs are don't-care but driven 0.
- Load-use hazard (HAZARD_EN=1):
  - Condition: ex_valid_o & MemRead_o & rt_o!=0 & instr_valid_i & (rt_o==rs || (rt_o==rt && instruction reads rt)).
  - "Reads rt" = R-type, SW, BEQ, BNE, BGT.
  - On hazard: stall_o=1 and a bubble is loaded next edge.
  - Stall lasts exactly one cycle, because the following cycle the EX slot is a bubble.
- Capture rules, in priority order:
  1. flush_i=1: load a bubble; stall_o forced 0.
  2. Hazard: load a bubble; stall_o=1.
  3. instr_valid_i=0: load a bubble.
  4. Otherwise load the decoded word with ex_valid_o=1.
- Unknown opcode (including extended branches when EXT_BRANCH=0): load a bubble and set illegal_o=1 for one cycle. Suppressed by flush.
- Reset (rst_n=0, asynchronous): ex_valid_o=0, all control outputs=0, ALU_op_o=0, addresses=0, illegal_o=0.
  - stall_o=0 during reset.
  - First capture occurs on the first rising edge after deassertion.
  - Reset mid-stall discards the stalled instruction; IF refetches it.
- Simultaneous flush and hazard: flush wins, so there is no stall.
- Back-to-back LW: the second LW stalls only if its rs matches the first LW's rt.

Decomposition:
- Package cpu_ctrl_pkg holds the opcode localparams, ALU_op class constants, BranchType encodings and a control-word struct (RegWrite..MemtoReg, ALU_op, BranchType).
- One natural sub-module: ctrl_decode_comb. It is purely combinational (opcode/funct -> control word + illegal flag) and reusable by a future single-cycle build.
- The hazard comparison and the register stay in id_ctrl_stage.

Test Plan:
- Reset: hold rst_n=0 with instr_i=ADDI and valid=1 -> all outputs 0, stall_o=0. Release -> the next edge gives ex_valid_o=1, ALU_op_o=2, RegWrite_o=1, ALUSrc_o=1.
- Load-use: LW $t1(rt=9) followed by ADD with rs=9 -> stall_o=1 for exactly one cycle, then a bubble (ex_valid_o=0), then ADD with ALU_op_o=1 and RegDst_o=1.
- No false stall: LW with rt=0, then ADD with rs=0 -> stall_o stays 0. LW rt=9, then ADDI rt=9 rs=3 -> no stall.
- Flush priority: hazard condition with flush_i=1 in the same cycle -> stall_o=0, bubble loaded, illegal_o=0.
- Extended branches: opcode 7 with EXT_BRANCH=1 -> Branch_o=1, BranchType_o=10, ALU_op_o=10. Same opcode with EXT_BRANCH=0 -> bubble and a one-cycle illegal_o pulse.
- Async reset mid-stall: assert rst_n low between edges while stall_o=1 -> outputs clear immediately, without waiting for a clock edge.
